// File: rtl/fft_seq_pkg.sv
// Shared constants and helpers for the radix-2 DIT FFT stage sequencer.
// Optional bit-reverse pass is enabled by defining FFT_SEQ_BITREV_EN.
package fft_seq_pkg;

   localparam int FFT_SEQ_MIN_LOG2 = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_BITREV = 3'd1;
   localparam state_t ST_ISSUE  = 3'd2;
   localparam state_t ST_DRAIN  = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   // Counter must hold the value MAX_OUTSTANDING itself, not just up to it minus one.
   function automatic int outstanding_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/fft_seq_bitrev.sv
// Combinational reversal of the low len_log2 bits of an index (upper bits assumed zero).
module fft_seq_bitrev #(
   parameter int W = 12
) (
   input  logic [W-1:0] idx,
   input  logic [3:0]   len_log2,
   output logic [W-1:0] rev
);

   logic [W-1:0] mirrored;

   // Mirror all W bits, then shift the reversed L-bit field down to bit 0.
   always_comb begin
      for (int b = 0; b < W; b++) begin
         mirrored[b] = idx[W-1-b];
      end
      rev = mirrored >> (4'(W) - len_log2);
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issues radix-2 DIT butterflies stage by stage, draining in-flight ops between stages.
// Define FFT_SEQ_BITREV_EN to prepend an in-place bit-reverse swap pass.
module fft_stage_sequencer
   import fft_seq_pkg::*;
#(
   parameter int FFT_MAX_LENGTH_LOG2 = 12,
   parameter int MAX_OUTSTANDING     = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [3:0]                     length_log2_i,
   output logic                           bfly_valid_o,
   input  logic                           bfly_ready_i,
   output logic [FFT_MAX_LENGTH_LOG2-1:0] addr_a_o,
   output logic [FFT_MAX_LENGTH_LOG2-1:0] addr_b_o,
   output logic [FFT_MAX_LENGTH_LOG2-2:0] twiddle_idx_o,
   output logic [3:0]                     stage_o,
   output logic                           swap_o,
   input  logic                           wb_valid_i,
   input  logic                           ovf_i,
   output logic                           busy_o,
   output logic                           stage_done_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic [7:0]                     scale_factor_o
);

   localparam int ADDR_W = FFT_MAX_LENGTH_LOG2;
   localparam int OUT_W  = outstanding_width(MAX_OUTSTANDING);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] k, k_nx;
   logic [3:0]        stage, stage_nx, len, len_nx;
   logic [OUT_W-1:0]  outstanding, outstanding_nx;
   logic              ovf_sticky, ovf_sticky_nx;
   logic              bitrev_pass, bitrev_pass_nx;
   logic [7:0]        scale_nx;
   logic              stage_done_nx, error_nx;
   logic              issue_req, handshake, stray_wb, len_ok;
   logic [ADDR_W-1:0] stage_bit, stage_mask, pair_a, half_last, index_last;
   logic [ADDR_W-2:0] tw_idx;

`ifdef FFT_SEQ_BITREV_EN
   logic [ADDR_W-1:0] rev_idx;

   fft_seq_bitrev #(.W(ADDR_W)) u_bitrev (
      .idx      (k),
      .len_log2 (len),
      .rev      (rev_idx)
   );

   // Each swap pair is visited twice in the scan; only the lower index issues it.
   assign issue_req = (state == ST_ISSUE) || ((state == ST_BITREV) && (k < rev_idx));
`else
   assign issue_req = (state == ST_ISSUE);
`endif

   assign bfly_valid_o = issue_req && (outstanding < OUT_W'(MAX_OUTSTANDING));
   assign handshake    = bfly_valid_o && bfly_ready_i;
   assign stray_wb     = (state != ST_IDLE) && wb_valid_i && !handshake && (outstanding == '0);
   assign len_ok       = (length_log2_i >= 4'(FFT_SEQ_MIN_LOG2)) &&
                         (length_log2_i <= 4'(FFT_MAX_LENGTH_LOG2));
   assign stage_o      = stage;

   // Butterfly index math for op k of the current stage.
   always_comb begin
      stage_bit  = ADDR_W'(1'b1) << stage;
      stage_mask = stage_bit - ADDR_W'(1'b1);
      pair_a     = ((k >> stage) << (stage + 4'd1)) | (k & stage_mask);
      tw_idx     = (k[ADDR_W-2:0] & stage_mask[ADDR_W-2:0]) << (len - 4'd1 - stage);
      half_last  = (ADDR_W'(1'b1) << (len - 4'd1)) - ADDR_W'(1'b1);
      index_last = (ADDR_W'(1'b1) << len) - ADDR_W'(1'b1);
   end

   // Operand outputs; held at zero outside the issuing states.
   always_comb begin
      addr_a_o      = '0;
      addr_b_o      = '0;
      twiddle_idx_o = '0;
      swap_o        = 1'b0;
      if (state == ST_ISSUE) begin
         addr_a_o      = pair_a;
         addr_b_o      = pair_a + stage_bit;
         twiddle_idx_o = tw_idx;
      end
`ifdef FFT_SEQ_BITREV_EN
      else if (state == ST_BITREV) begin
         addr_a_o = k;
         addr_b_o = rev_idx;
         swap_o   = 1'b1;
      end
`endif
      else begin
         swap_o = 1'b0;
      end
   end

   // Next-state, counters and pulse decisions; abort overrides everything.
   always_comb begin
      state_nx       = state;
      k_nx           = k;
      stage_nx       = stage;
      len_nx         = len;
      scale_nx       = scale_factor_o;
      bitrev_pass_nx = bitrev_pass;
      stage_done_nx  = 1'b0;
      error_nx       = 1'b0;
      if (handshake && !wb_valid_i) begin
         outstanding_nx = outstanding + OUT_W'(1'b1);
      end else if (!handshake && wb_valid_i && (outstanding != '0)) begin
         outstanding_nx = outstanding - OUT_W'(1'b1);
      end else begin
         outstanding_nx = outstanding;
      end
      if ((state == ST_ISSUE) || (state == ST_DRAIN)) begin
         ovf_sticky_nx = ovf_sticky | ovf_i;
      end else begin
         ovf_sticky_nx = ovf_sticky;
      end

      case (state)
         ST_IDLE: begin
            if (start_i && len_ok) begin
               len_nx        = length_log2_i;
               scale_nx      = 8'd0;
               k_nx          = '0;
               stage_nx      = 4'd0;
               ovf_sticky_nx = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
               state_nx       = ST_BITREV;
               bitrev_pass_nx = 1'b1;
`else
               state_nx       = ST_ISSUE;
`endif
            end else if (start_i) begin
               error_nx = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
`ifdef FFT_SEQ_BITREV_EN
         ST_BITREV: begin
            if (handshake || !issue_req) begin
               if (k == index_last) begin
                  state_nx = ST_DRAIN;
               end else begin
                  k_nx = k + ADDR_W'(1'b1);
               end
            end else begin
               state_nx = ST_BITREV;
            end
         end
`endif
         ST_ISSUE: begin
            if (handshake) begin
               if (k == half_last) begin
                  state_nx = ST_DRAIN;
               end else begin
                  k_nx = k + ADDR_W'(1'b1);
               end
            end else begin
               state_nx = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (outstanding == '0) begin
               k_nx          = '0;
               ovf_sticky_nx = 1'b0;
               if (bitrev_pass) begin
                  bitrev_pass_nx = 1'b0;
                  state_nx       = ST_ISSUE;
               end else begin
                  stage_done_nx = 1'b1;
                  if ((ovf_sticky || ovf_i) && (scale_factor_o != 8'hFF)) begin
                     scale_nx = scale_factor_o + 8'd1;
                  end else begin
                     scale_nx = scale_factor_o;
                  end
                  if (stage < (len - 4'd1)) begin
                     stage_nx = stage + 4'd1;
                     state_nx = ST_ISSUE;
                  end else begin
                     state_nx = ST_DONE;
                  end
               end
            end else begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      if (stray_wb) begin
         state_nx       = ST_IDLE;
         error_nx       = 1'b1;
         stage_done_nx  = 1'b0;
         bitrev_pass_nx = 1'b0;
      end else begin
         error_nx = error_nx;
      end

      if (abort_i) begin
         state_nx       = ST_IDLE;
         outstanding_nx = '0;
         ovf_sticky_nx  = 1'b0;
         bitrev_pass_nx = 1'b0;
         stage_done_nx  = 1'b0;
         error_nx       = 1'b0;
      end else begin
         state_nx = state_nx;
      end
   end

   // State and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state          <= ST_IDLE;
         k              <= '0;
         stage          <= 4'd0;
         len            <= 4'd0;
         outstanding    <= '0;
         ovf_sticky     <= 1'b0;
         bitrev_pass    <= 1'b0;
         scale_factor_o <= 8'd0;
         busy_o         <= 1'b0;
         stage_done_o   <= 1'b0;
         done_o         <= 1'b0;
         error_o        <= 1'b0;
      end else begin
         state          <= state_nx;
         k              <= k_nx;
         stage          <= stage_nx;
         len            <= len_nx;
         outstanding    <= outstanding_nx;
         ovf_sticky     <= ovf_sticky_nx;
         bitrev_pass    <= bitrev_pass_nx;
         scale_factor_o <= scale_nx;
         busy_o         <= (state_nx != ST_IDLE);
         stage_done_o   <= stage_done_nx;
         done_o         <= (state_nx == ST_DONE);
         error_o        <= error_nx;
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised self-checking bench for fft_stage_sequencer against a group/offset butterfly model.
// Honours FFT_SEQ_BITREV_EN when it is defined for the whole build.
module tb_fft_stage_sequencer;

   localparam int AW   = 12;
   localparam int MAXO = 8;

   logic          clk = 1'b0;
   logic          reset_i, start_i, abort_i, bfly_ready_i, wb_valid_i, ovf_i;
   logic [3:0]    length_log2_i;
   logic          bfly_valid_o, swap_o, busy_o, stage_done_o, done_o, error_o;
   logic [AW-1:0] addr_a_o, addr_b_o;
   logic [AW-2:0] twiddle_idx_o;
   logic [3:0]    stage_o;
   logic [7:0]    scale_factor_o;

   int            tests = 0;
   int            fails = 0;
   int            nswap = 0;
   logic [39:0]   exp_q[$];
   logic [39:0]   op_log[$];
   int            op_cyc[$];
   int            pend[$];

   always #5 clk = ~clk;

   fft_stage_sequencer #(.FFT_MAX_LENGTH_LOG2(AW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
      .length_log2_i(length_log2_i), .bfly_valid_o(bfly_valid_o), .bfly_ready_i(bfly_ready_i),
      .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .twiddle_idx_o(twiddle_idx_o),
      .stage_o(stage_o), .swap_o(swap_o), .wb_valid_i(wb_valid_i), .ovf_i(ovf_i),
      .busy_o(busy_o), .stage_done_o(stage_done_o), .done_o(done_o), .error_o(error_o),
      .scale_factor_o(scale_factor_o)
   );

   function automatic logic [39:0] pk(input int sw, input int st, input int tw, input int b, input int a);
      return {sw[0], st[3:0], tw[10:0], b[11:0], a[11:0]};
   endfunction

   function automatic int rev_bits(input int v, input int l);
      int r = 0;
      for (int i = 0; i < l; i++) if (((v >> i) & 1) == 1) r = r | (1 << (l - 1 - i));
      return r;
   endfunction

   function automatic logic [39:0] cur_op();
      return pk(int'(swap_o), int'(stage_o), int'(twiddle_idx_o), int'(addr_b_o), int'(addr_a_o));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int l, input int rdy_pct, input int wb_pct, input int ovf_mask, input int abort_stage);
      int          n, sd, dn, er, ncyc, outst, max_out, ovf_seen, abort_cnt, exp_scale, half;
      logic        ready, wbv, hs, stall, abort_next, aborted, finished, ovf_pulse;
      logic [39:0] held, got, want;
      half = 1 << (l - 1);
      exp_q.delete(); op_log.delete(); op_cyc.delete(); pend.delete();
      nswap = 0;
`ifdef FFT_SEQ_BITREV_EN
      for (int i = 0; i < (1 << l); i++) begin
         if (i < rev_bits(i, l)) begin
            exp_q.push_back(pk(1, 0, 0, rev_bits(i, l), i));
            nswap++;
         end
      end
`endif
      // Stage s: groups of 2^(s+1) points, pair offset j, twiddle stride 2^(l-1-s).
      for (int s = 0; s < l; s++)
         for (int g = 0; g < (1 << l); g += (2 << s))
            for (int j = 0; j < (1 << s); j++)
               exp_q.push_back(pk(0, s, j << (l - 1 - s), g + j + (1 << s), g + j));
      exp_scale = 0;
      for (int s = 0; s < l; s++) if (((ovf_mask >> s) & 1) == 1) exp_scale++;

      length_log2_i = 4'(l);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("busy_after_start", 64'(busy_o), 64'd1);
      chk("scale_cleared", 64'(scale_factor_o), 64'd0);
      n = 0; sd = 0; dn = 0; er = 0; ncyc = 0; outst = 0; max_out = 0; ovf_seen = 0; abort_cnt = 0;
      stall = 1'b0; abort_next = 1'b0; aborted = 1'b0; finished = 1'b0; ovf_pulse = 1'b0; held = '0;
      while (!finished) begin
         ready = ($urandom_range(99) < rdy_pct);
         wbv = (pend.size() > 0) && (pend[0] <= ncyc) && ($urandom_range(99) < wb_pct);
         bfly_ready_i = ready;
         wb_valid_i = wbv;
         ovf_i = ovf_pulse;
         ovf_pulse = 1'b0;
         abort_i = abort_next;
         aborted = abort_next;
         abort_next = 1'b0;
         if (stall) chk("hold_while_stalled", {23'd0, bfly_valid_o, cur_op()}, {23'd0, 1'b1, held});
         if (outst == MAXO) chk("valid_at_max_outstanding", 64'(bfly_valid_o), 64'd0);
         hs = bfly_valid_o && ready;
         if (hs) begin
            got = cur_op();
            op_log.push_back(got);
            op_cyc.push_back(ncyc);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
            chk($sformatf("op%0d", n), 64'(got), 64'(want));
            n++;
            pend.push_back(ncyc + 4);
            if (!swap_o && (((ovf_mask >> stage_o) & 1) == 1) && (((ovf_seen >> stage_o) & 1) == 0)) begin
               ovf_pulse = 1'b1;
               ovf_seen = ovf_seen | (1 << stage_o);
            end
            if (!swap_o && (int'(stage_o) == abort_stage)) begin
               abort_cnt++;
               if (abort_cnt == 10) abort_next = 1'b1;
            end
         end
         if (wbv) void'(pend.pop_front());
         outst = outst + int'(hs) - int'(wbv);
         if (outst > max_out) max_out = outst;
         stall = bfly_valid_o && !ready;
         held = cur_op();
         tick();
         ncyc++;
         if (stage_done_o) sd++;
         if (error_o) begin er++; finished = 1'b1; end
         if (done_o) begin
            dn++;
            finished = 1'b1;
            chk("busy_in_done_cycle", 64'(busy_o), 64'd1);
            chk("scale_at_done", 64'(scale_factor_o), 64'(exp_scale));
         end
         if (aborted) begin
            finished = 1'b1;
            chk("abort_idle", {62'd0, busy_o, bfly_valid_o}, 64'd0);
         end
         if (ncyc > 30000) begin
            finished = 1'b1;
            chk("run_timeout", 64'(ncyc), 64'd0);
         end
      end
      bfly_ready_i = 1'b0; wb_valid_i = 1'b0; ovf_i = 1'b0; abort_i = 1'b0;
      pend.delete();
      chk("no_error", 64'(er), 64'd0);
      if (aborted) begin
         for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_done_after_abort", {61'd0, done_o, stage_done_o, busy_o}, 64'd0);
         end
      end else begin
         chk("op_count", 64'(n), 64'(nswap + l * half));
         chk("stage_done_count", 64'(sd), 64'(l));
         chk("done_count", 64'(dn), 64'd1);
         if (wb_pct < 100) chk("reached_max_outstanding", 64'(max_out), 64'(MAXO));
         if (rdy_pct == 100 && wb_pct == 100)
            for (int s = 0; s < l; s++)
               chk($sformatf("zero_bubble_s%0d", s),
                   64'(op_cyc[nswap + s * half + half - 1] - op_cyc[nswap + s * half]), 64'(half - 1));
         tick();
         chk("idle_after_done", {62'd0, busy_o, done_o}, 64'd0);
      end
   endtask

   initial begin
      int bad[2];
      bad = '{7, 13};
      reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; bfly_ready_i = 1'b0;
      wb_valid_i = 1'b0; ovf_i = 1'b0; length_log2_i = 4'd8;
      repeat (3) tick();
      reset_i = 1'b0;
      tick();
      chk("reset_ops", {bfly_valid_o, addr_a_o, addr_b_o, twiddle_idx_o, stage_o, swap_o}, 64'd0);
      chk("reset_status", {busy_o, stage_done_o, done_o, error_o, scale_factor_o}, 64'd0);

      for (int i = 0; i < 2; i++) begin
         length_log2_i = 4'(bad[i]);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         chk($sformatf("bad_len%0d_error", bad[i]), {62'd0, error_o, busy_o}, 64'd2);
         tick();
         chk($sformatf("bad_len%0d_after", bad[i]), {62'd0, error_o, busy_o}, 64'd0);
      end

      run(8, 100, 100, 0, -1);
      chk("s0_op0", 64'(op_log[nswap + 0]), 64'(pk(0, 0, 0, 1, 0)));
      chk("s0_op1", 64'(op_log[nswap + 1]), 64'(pk(0, 0, 0, 3, 2)));
      chk("s1_op0", 64'(op_log[nswap + 128]), 64'(pk(0, 1, 0, 2, 0)));
      chk("s1_op1", 64'(op_log[nswap + 129]), 64'(pk(0, 1, 64, 3, 1)));
      chk("s7_op0", 64'(op_log[nswap + 896]), 64'(pk(0, 7, 0, 128, 0)));
      chk("s7_op1", 64'(op_log[nswap + 897]), 64'(pk(0, 7, 1, 129, 1)));
`ifdef FFT_SEQ_BITREV_EN
      chk("swap_count", 64'(nswap), 64'd120);
      chk("swap_op0", 64'(op_log[0]), 64'(pk(1, 0, 0, 128, 1)));
      chk("swap_op1", 64'(op_log[1]), 64'(pk(1, 0, 0, 64, 2)));
`endif

      run(8 + int'($urandom_range(1)), 50, 25, 0, -1);

      run(8, 70, 100, 32'h24, -1);
      repeat (5) tick();
      chk("scale_held", 64'(scale_factor_o), 64'd2);

      run(8, 100, 100, 0, 3);
      run(8, 100, 100, 0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
